// File: rtl/eof_delay_pulse_mc.sv
// Multi-channel end-of-frame delayed-pulse generator: each EOF strobe starts a
// programmable countdown, and expiry of that countdown emits a PULSE_LEN-cycle pulse.
module eof_delay_pulse_mc #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 6,
  parameter int PULSE_LEN = 1,
  parameter int MAX_PEND  = 3,
  parameter int RETRIG    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] eof,
  input  logic [CNT_W-1:0]  cfg_delay,
  input  logic [NUM_CH-1:0] ovf_clr,
  output logic [NUM_CH-1:0] op,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf,
  output logic              sig
);

  localparam int PEND_W = $clog2(MAX_PEND + 1);
  localparam int PLEN_W = $clog2(PULSE_LEN + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
  localparam logic [PLEN_W-1:0] PLEN_END = PLEN_W'(PULSE_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_PULSE
  } state_t;

  state_t            state_q   [NUM_CH];
  state_t            state_d   [NUM_CH];
  logic [CNT_W-1:0]  cnt_q     [NUM_CH];
  logic [CNT_W-1:0]  cnt_d     [NUM_CH];
  logic [CNT_W-1:0]  dly_q     [NUM_CH];
  logic [CNT_W-1:0]  dly_d     [NUM_CH];
  logic [PEND_W-1:0] pending_q [NUM_CH];
  logic [PEND_W-1:0] pending_d [NUM_CH];
  logic [PLEN_W-1:0] plen_q    [NUM_CH];
  logic [PLEN_W-1:0] plen_d    [NUM_CH];
  logic [NUM_CH-1:0] op_q, op_d;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] enq;
  logic              sig_q, sig_d;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    enq   = '0;
    op_d  = op_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      dly_d[i]     = dly_q[i];
      pending_d[i] = pending_q[i];
      plen_d[i]    = plen_q[i];

      case (state_q[i])
        S_IDLE: begin
          if (eof[i]) begin
            state_d[i] = S_COUNT;
            cnt_d[i]   = '0;
            dly_d[i]   = cfg_delay;
          end
        end
        S_COUNT: begin
          if (RETRIG != 0 && eof[i]) begin
            cnt_d[i] = '0;
            dly_d[i] = cfg_delay;
          end else begin
            enq[i] = eof[i];
            if (cnt_q[i] == dly_q[i]) begin
              state_d[i] = S_PULSE;
              op_d[i]    = 1'b1;
              plen_d[i]  = PLEN_W'(1);
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        S_PULSE: begin
          if (plen_q[i] == PLEN_END) begin
            op_d[i] = 1'b0;
            // An EOF on the final pulse edge is consumed here: with a queue it
            // replaces the entry being popped, otherwise it starts directly.
            if (pending_q[i] != '0 || eof[i]) begin
              state_d[i] = S_COUNT;
              cnt_d[i]   = '0;
              dly_d[i]   = cfg_delay;
              if (!eof[i]) pending_d[i] = pending_q[i] - 1'b1;
            end else begin
              state_d[i] = S_IDLE;
            end
          end else begin
            plen_d[i] = plen_q[i] + 1'b1;
            enq[i]    = eof[i];
          end
        end
        default: state_d[i] = S_IDLE;
      endcase

      if (enq[i]) begin
        if (pending_q[i] == PEND_MAX) ovf_d[i] = 1'b1;
        else                          pending_d[i] = pending_q[i] + 1'b1;
      end
      if (ovf_clr[i]) ovf_d[i] = 1'b0;
    end
    sig_d = |op_d;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (state_q[i] != S_IDLE) || (pending_q[i] != '0);
    end
  end

  // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= S_IDLE;
        cnt_q[i]     <= '0;
        dly_q[i]     <= '0;
        pending_q[i] <= '0;
        plen_q[i]    <= '0;
      end
      op_q  <= '0;
      ovf_q <= '0;
      sig_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= state_d[i];
        cnt_q[i]     <= cnt_d[i];
        dly_q[i]     <= dly_d[i];
        pending_q[i] <= pending_d[i];
        plen_q[i]    <= plen_d[i];
      end
      op_q  <= op_d;
      ovf_q <= ovf_d;
      sig_q <= sig_d;
    end
  end

  assign op  = op_q;
  assign ovf = ovf_q;
  assign sig = sig_q;

endmodule

// File: tb/tb_eof_delay_pulse_mc.sv
// Directed bench for eof_delay_pulse_mc: default, retrigger and wide-pulse
// instances driven by a linear sequence of hand-computed steps.
module tb_eof_delay_pulse_mc;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] cfg_delay;
  logic [3:0] ovf_clr;
  logic [3:0] eof_a, op_a, busy_a, ovf_a;
  logic [3:0] eof_b, op_b, busy_b, ovf_b;
  logic [3:0] eof_c, op_c, busy_c, ovf_c;
  logic       sig_a, sig_b, sig_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  eof_delay_pulse_mc u_a (
    .clock(clock), .reset(reset), .eof(eof_a), .cfg_delay(cfg_delay),
    .ovf_clr(ovf_clr), .op(op_a), .busy(busy_a), .ovf(ovf_a), .sig(sig_a)
  );

  eof_delay_pulse_mc #(.RETRIG(1)) u_b (
    .clock(clock), .reset(reset), .eof(eof_b), .cfg_delay(cfg_delay),
    .ovf_clr(ovf_clr), .op(op_b), .busy(busy_b), .ovf(ovf_b), .sig(sig_b)
  );

  eof_delay_pulse_mc #(.PULSE_LEN(4)) u_c (
    .clock(clock), .reset(reset), .eof(eof_c), .cfg_delay(cfg_delay),
    .ovf_clr(ovf_clr), .op(op_c), .busy(busy_c), .ovf(ovf_c), .sig(sig_c)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel 1, delay 5: EOF held for n_eof edges. Pulses land on edges 6, 13, 20, 27
  // after the first EOF edge (edge 0); the queue drains at edge 28.
  task automatic run_queue(input int n_eof, input string tag);
    logic [3:0] exp_op;
    cfg_delay = 6'd5;
    eof_a     = 4'b0010;
    for (int k = 0; k < 35; k++) begin
      step();
      if (k == n_eof - 1) eof_a = 4'b0000;
      exp_op = (k == 6 || k == 13 || k == 20 || k == 27) ? 4'b0010 : 4'b0000;
      check({tag, "_op"},   32'(op_a),   32'(exp_op));
      check({tag, "_sig"},  32'(sig_a),  32'(|exp_op));
      check({tag, "_busy"}, 32'(busy_a), (k < 28) ? 32'h2 : 32'h0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    eof_a     = '0;
    eof_b     = '0;
    eof_c     = '0;
    ovf_clr   = '0;
    cfg_delay = '0;

    // Reset state, with EOFs presented during reset
    step();
    eof_a = 4'hF;
    step();
    step();
    check("rst_op",   32'(op_a),   32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_ovf",  32'(ovf_a),  32'h0);
    check("rst_sig",  32'(sig_a),  32'h0);
    eof_a = '0;
    reset = 1'b0;
    step();
    check("rst_eof_ignored", 32'(busy_a), 32'h0);

    // Single EOF on ch0, delay 42: pulse on edge E0+43 only
    cfg_delay = 6'd42;
    eof_a     = 4'b0001;
    step();
    eof_a = '0;
    check("d42_busy", 32'(busy_a), 32'h1);
    repeat (42) step();
    check("d42_early_op", 32'(op_a), 32'h0);
    step();
    check("d42_op",  32'(op_a),  32'h1);
    check("d42_sig", 32'(sig_a), 32'h1);
    step();
    check("d42_op_end",  32'(op_a),   32'h0);
    check("d42_sig_end", 32'(sig_a),  32'h0);
    check("d42_idle",    32'(busy_a), 32'h0);

    // Delay 0 on ch2: pulse on the very next edge
    cfg_delay = 6'd0;
    eof_a     = 4'b0100;
    step();
    eof_a = '0;
    check("d0_e0", 32'(op_a), 32'h0);
    step();
    check("d0_op", 32'(op_a), 32'h4);
    step();
    check("d0_end", 32'(op_a), 32'h0);

    // Delay 63 on ch3; cfg_delay changed after start must not matter
    cfg_delay = 6'd63;
    eof_a     = 4'b1000;
    step();
    eof_a     = '0;
    cfg_delay = 6'd0;
    repeat (63) step();
    check("d63_early_op", 32'(op_a),   32'h0);
    check("d63_busy",     32'(busy_a), 32'h8);
    step();
    check("d63_op", 32'(op_a), 32'h8);
    step();
    check("d63_end",  32'(op_a),   32'h0);
    check("d63_idle", 32'(busy_a), 32'h0);

    // Queue: 1 + 3 EOFs -> 4 pulses, no overflow
    run_queue(4, "q3");
    check("q3_ovf", 32'(ovf_a), 32'h0);

    // Saturation: 1 + 5 EOFs -> 4 pulses, ovf[1] sticky until cleared
    run_queue(6, "q5");
    check("q5_ovf", 32'(ovf_a), 32'h2);
    repeat (3) step();
    check("q5_ovf_held", 32'(ovf_a), 32'h2);
    ovf_clr = 4'b0010;
    step();
    ovf_clr = '0;
    check("q5_ovf_clr", 32'(ovf_a), 32'h0);

    // Retrigger: second EOF while cnt=3 restarts the delay-10 countdown
    cfg_delay = 6'd10;
    eof_b     = 4'b0001;
    step();
    eof_b = '0;
    repeat (3) step();
    eof_b = 4'b0001;
    step();
    eof_b = '0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("rt_op",  32'(op_b),  (k == 11) ? 32'h1 : 32'h0);
      check("rt_sig", 32'(sig_b), (k == 11) ? 32'h1 : 32'h0);
    end
    check("rt_idle", 32'(busy_b), 32'h0);

    // PULSE_LEN=4, delay 2: op high on edges E0+3..E0+6
    cfg_delay = 6'd2;
    eof_c     = 4'b0001;
    step();
    eof_c = '0;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("pl4_op", 32'(op_c), (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
    end
    check("pl4_idle", 32'(busy_c), 32'h0);

    // Reset mid-COUNT with a full queue and ovf set
    cfg_delay = 6'd20;
    eof_a     = 4'b0001;
    repeat (5) step();
    eof_a = '0;
    repeat (3) step();
    check("mid_cnt_busy", 32'(busy_a), 32'h1);
    check("mid_cnt_ovf",  32'(ovf_a),  32'h1);
    reset = 1'b1;
    step();
    check("rst_cnt_op",   32'(op_a),   32'h0);
    check("rst_cnt_busy", 32'(busy_a), 32'h0);
    check("rst_cnt_ovf",  32'(ovf_a),  32'h0);
    check("rst_cnt_sig",  32'(sig_a),  32'h0);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      check("rst_cnt_stale", 32'(op_a), 32'h0);
    end

    // Reset mid-PULSE on the wide-pulse instance
    cfg_delay = 6'd3;
    eof_c     = 4'b0010;
    step();
    eof_c = '0;
    repeat (4) step();
    check("mid_pl_op", 32'(op_c), 32'h2);
    step();
    step();
    check("mid_pl_op_held", 32'(op_c),  32'h2);
    check("mid_pl_sig",     32'(sig_c), 32'h1);
    reset = 1'b1;
    step();
    check("rst_pl_op",   32'(op_c),   32'h0);
    check("rst_pl_sig",  32'(sig_c),  32'h0);
    check("rst_pl_busy", 32'(busy_c), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("rst_pl_stale", 32'(op_c), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
